// File: rtl/serializer_sched_pkg.sv
// Shared constants for the serializer scheduler: FSM state codes, watchdog
// offset, word-counter width and the round-robin pointer increment helper.
package serializer_sched_pkg;

  // FSM state codes (2 bits)
  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Default slack added to the word width to form the watchdog limit
  localparam int WDOG_OFFSET = 4;

  // Width of the issued-word counter
  localparam int WORDS_W = 16;

  // Index following idx in a ring of n entries
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    if (idx + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/serializer_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after the
// pointer, wrapping to the lowest eligible index when none is found above it.
module rr_arbiter
  import serializer_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOG2NREQ = 2
) (
  input  logic [NREQ-1:0]     elig_i,
  input  logic [LOG2NREQ-1:0] ptr_i,
  output logic [LOG2NREQ-1:0] winner_o,
  output logic                any_o
);

  logic                hi_found_s;
  logic [LOG2NREQ-1:0] hi_idx_s;
  logic                lo_found_s;
  logic [LOG2NREQ-1:0] lo_idx_s;

  // Scan for the first eligible index at/above the pointer and the lowest overall
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig_i[i] && !hi_found_s && (LOG2NREQ'(i) >= ptr_i)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = LOG2NREQ'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
      if (elig_i[i] && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_idx_s   = LOG2NREQ'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
  end

  // Wrap-around falls back to the lowest eligible index
  always_comb begin
    if (hi_found_s) begin
      winner_o = hi_idx_s;
    end else begin
      winner_o = lo_idx_s;
    end
    any_o = lo_found_s;
  end

endmodule

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one wide-to-serial shifter among NREQ
// requesters: arbitrate, capture the word, pulse a load, tag the stream with
// its owner and wait for the stream to finish (with a stall watchdog).
module serializer_scheduler
  import serializer_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOG2NREQ = 2,
  parameter int FROM     = 256,
  parameter int LOG2FROM = 8,
  parameter int WDOG     = FROM + WDOG_OFFSET
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ*FROM-1:0] req_data_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_en_i,
  output logic [FROM-1:0]      ser_data_o,
  output logic                 ser_valid_o,
  input  logic                 ser_ready_i,
  input  logic                 ser_busy_i,
  output logic [LOG2NREQ-1:0]  tag_id_o,
  output logic                 tag_valid_o,
  output logic                 err_o,
  output logic [WORDS_W-1:0]   words_o
);

  // Watchdog wide enough for WDOG and never narrower than the shift length
  localparam int WDW_MIN = $clog2(WDOG + 1);
  localparam int WDW     = (WDW_MIN > LOG2FROM + 1) ? WDW_MIN : LOG2FROM + 1;
  localparam logic [WDW-1:0]  WDOG_LIM = WDW'(WDOG);
  localparam logic [NREQ-1:0] REQ_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [LOG2NREQ-1:0] ptr_q, ptr_d;
  logic [FROM-1:0]     hold_q, hold_d;
  logic [LOG2NREQ-1:0] tag_q, tag_d;
  logic [WORDS_W-1:0]  words_q, words_d;
  logic                err_q, err_d;
  logic [WDW-1:0]      wdog_q, wdog_d;
  logic                seen_q, seen_d;
  logic                ser_valid_q, ser_valid_d;
  logic                tag_valid_q, tag_valid_d;

  logic [NREQ-1:0]     elig_s;
  logic [LOG2NREQ-1:0] winner_s;
  logic                any_s;
  logic                grant_s;

  assign elig_s = req_valid_i & req_en_i;

  rr_arbiter #(
    .NREQ     (NREQ),
    .LOG2NREQ (LOG2NREQ)
  ) u_rr_arbiter (
    .elig_i   (elig_s),
    .ptr_i    (ptr_q),
    .winner_o (winner_s),
    .any_o    (any_s)
  );

  // A grant needs an idle serializer and an eligible requester; never during reset
  assign grant_s = reset_n & (state_q == ST_ARB) & ser_ready_i & any_s;

  // One-hot accept pulse to the winner in the grant cycle
  always_comb begin
    if (grant_s) begin
      req_ready_o = REQ_ONE << winner_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Next-state logic: arbitration, load, and stream/watchdog tracking
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tag_d   = tag_q;
    words_d = words_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    seen_d  = seen_q;
    case (state_q)
      ST_ARB: begin
        if (grant_s) begin
          hold_d  = req_data_i[int'(winner_s)*FROM +: FROM];
          tag_d   = winner_s;
          ptr_d   = LOG2NREQ'(rr_next(32'(winner_s), NREQ));
          state_d = ST_LOAD;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_LOAD: begin
        words_d = words_q + WORDS_W'(1'b1);
        wdog_d  = '0;
        seen_d  = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        wdog_d = wdog_q + WDW'(1'b1);
        if (seen_q && !ser_busy_i) begin
          // stream finished: first idle cycle after busy was observed
          state_d = ST_ARB;
        end else if (wdog_d == WDOG_LIM) begin
          err_d   = 1'b1;
          state_d = ST_ARB;
        end else begin
          seen_d = seen_q | ser_busy_i;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Registered decode of the load pulse and tag qualifier from the next state
  always_comb begin
    ser_valid_d = (state_d == ST_LOAD);
    tag_valid_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      hold_q      <= '0;
      tag_q       <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
      seen_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      tag_q       <= tag_d;
      words_q     <= words_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
      seen_q      <= seen_d;
      ser_valid_q <= ser_valid_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  assign ser_data_o  = hold_q;
  assign ser_valid_o = ser_valid_q;
  assign tag_id_o    = tag_q;
  assign tag_valid_o = tag_valid_q;
  assign err_o       = err_q;
  assign words_o     = words_q;

endmodule

// File: tb/tb_serializer_scheduler.sv
// Self-checking bench for serializer_scheduler: the bench plays the requesters
// and the serializer, and a transaction-level reference model predicts every
// output cycle by cycle.
module tb_serializer_scheduler;

  localparam int NREQ     = 4;
  localparam int LOG2NREQ = 2;
  localparam int FROM     = 32;
  localparam int LOG2FROM = 5;
  localparam int WDOG     = FROM + 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ*FROM-1:0] req_data_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ-1:0]      req_en_i;
  logic [FROM-1:0]      ser_data_o;
  logic                 ser_valid_o;
  logic                 ser_ready_i;
  logic                 ser_busy_i;
  logic [LOG2NREQ-1:0]  tag_id_o;
  logic                 tag_valid_o;
  logic                 err_o;
  logic [15:0]          words_o;

  serializer_scheduler #(
    .NREQ(NREQ), .LOG2NREQ(LOG2NREQ), .FROM(FROM), .LOG2FROM(LOG2FROM), .WDOG(WDOG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_en_i(req_en_i),
    .ser_data_o(ser_data_o), .ser_valid_o(ser_valid_o),
    .ser_ready_i(ser_ready_i), .ser_busy_i(ser_busy_i),
    .tag_id_o(tag_id_o), .tag_valid_o(tag_valid_o),
    .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  // stimulus knobs
  int req_mode    = 0;     // 0: refill while refill_left>0 else drop; 2: random
  int refill_left = 0;
  bit ser_ready_force = 1'b1;
  bit ser_stuck = 1'b0;
  int s_cnt = 0;
  int grant_log[$];        // requester indices actually accepted by the DUT

  // reference model: one transaction at a time (grant -> load -> stream)
  bit              m_load  = 1'b0;
  bit              m_shift = 1'b0;
  bit              m_seen  = 1'b0;
  bit              m_err   = 1'b0;
  int              m_wd    = 0;
  int              m_ptr   = 0;
  int              m_tag   = 0;
  logic [FROM-1:0] m_word  = '0;
  logic [15:0]     m_words = '0;

  task automatic check(input string tag, input logic [FROM-1:0] obs, input logic [FROM-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] elig);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr + k) % NREQ;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] act_rdy;
    bit act_load;
    bit busy_now;
    bit grant;
    int win;
    @(negedge clk);
    elig  = req_valid_i & req_en_i;
    win   = rr_pick(m_ptr, elig);
    grant = reset_n && !m_load && !m_shift && ser_ready_i && (win >= 0);
    exp_rdy = '0;
    if (grant) exp_rdy[win] = 1'b1;
    if (chk_en) begin
      check("req_ready", FROM'(req_ready_o), FROM'(exp_rdy));
      check("ser_valid", FROM'(ser_valid_o), FROM'(m_load));
      check("ser_data", ser_data_o, m_word);
      check("tag_valid", FROM'(tag_valid_o), FROM'(m_load | m_shift));
      check("tag_id", FROM'(tag_id_o), FROM'(m_tag));
      check("err", FROM'(err_o), FROM'(m_err));
      check("words", FROM'(words_o), FROM'(m_words));
    end
    act_rdy  = req_ready_o;
    act_load = ser_valid_o;
    busy_now = ser_busy_i;
    @(posedge clk);
    if (!reset_n) begin
      m_load = 1'b0; m_shift = 1'b0; m_seen = 1'b0; m_err = 1'b0;
      m_wd = 0; m_ptr = 0; m_tag = 0; m_word = '0; m_words = '0;
    end else if (m_load) begin
      m_load = 1'b0; m_shift = 1'b1; m_wd = 0; m_seen = 1'b0; m_words = m_words + 16'd1;
    end else if (m_shift) begin
      m_wd++;
      if (m_seen && !busy_now) m_shift = 1'b0;
      else if (m_wd == WDOG) begin m_err = 1'b1; m_shift = 1'b0; end
      else if (busy_now) m_seen = 1'b1;
    end else if (grant) begin
      m_load = 1'b1;
      m_tag  = win;
      m_word = req_data_i[win*FROM +: FROM];
      m_ptr  = (win + 1) % NREQ;
    end
    #1;
    // requesters
    for (int i = 0; i < NREQ; i++) begin
      if (act_rdy[i] && req_valid_i[i]) begin
        grant_log.push_back(i);
        req_data_i[i*FROM +: FROM] = $urandom;
        if (req_mode == 2) req_valid_i[i] = ($urandom_range(0, 1) == 1);
        else if (refill_left > 0) begin req_valid_i[i] = 1'b1; refill_left--; end
        else req_valid_i[i] = 1'b0;
      end else if (!req_valid_i[i] && req_mode == 2 && $urandom_range(0, 2) == 0) begin
        req_valid_i[i] = 1'b1;
        req_data_i[i*FROM +: FROM] = $urandom;
      end
    end
    // serializer: busy starts the cycle after a load
    if (act_load) s_cnt = ser_stuck ? 1000000 : int'($urandom_range(1, 6));
    if (s_cnt > 0) begin ser_busy_i = 1'b1; s_cnt--; end
    else ser_busy_i = 1'b0;
    ser_ready_i = !ser_busy_i && ser_ready_force;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    grant_log.delete();
    check("rst_words", FROM'(words_o), FROM'(0));
    check("rst_err", FROM'(err_o), FROM'(0));
    check("rst_tag_valid", FROM'(tag_valid_o), FROM'(0));
    check("rst_ser_valid", FROM'(ser_valid_o), FROM'(0));
  endtask

  task automatic run_until_grants(input int n, input int budget, input string tag);
    int c = 0;
    while (grant_log.size() < n && c < budget) begin cycle(); c++; end
    check(tag, FROM'(grant_log.size() >= n), FROM'(1));
  endtask

  initial begin
    reset_n     = 1'b0;
    req_data_i  = '0;
    req_valid_i = '0;
    req_en_i    = 4'b1111;
    ser_ready_i = 1'b1;
    ser_busy_i  = 1'b0;

    // 1: single request from requester 0
    apply_reset();
    req_data_i[0 +: FROM] = 32'hA5A5_A5A5;
    req_valid_i = 4'b0001;
    cycle();
    check("t1_grant_cycle1", FROM'(grant_log.size()), FROM'(1));
    cycle();
    check("t1_data", ser_data_o, 32'hA5A5_A5A5);
    check("t1_tag", FROM'(tag_id_o), FROM'(0));
    repeat (12) cycle();
    check("t1_words", FROM'(words_o), FROM'(1));

    // 2: fairness, all four requesting
    apply_reset();
    refill_left = 2;
    req_valid_i = 4'b1111;
    run_until_grants(6, 200, "t2_six_grants");
    repeat (20) cycle();
    for (int k = 0; k < 6; k++)
      check("t2_order", FROM'(grant_log[k]), FROM'(k % NREQ));
    check("t2_words", FROM'(words_o), FROM'(6));

    // 3: enable mask 1010
    apply_reset();
    req_en_i    = 4'b1010;
    refill_left = 2;
    req_valid_i = 4'b1111;
    run_until_grants(4, 200, "t3_four_grants");
    repeat (20) cycle();
    check("t3_count", FROM'(grant_log.size()), FROM'(4));
    for (int k = 0; k < 4; k++)
      check("t3_order", FROM'(grant_log[k]), FROM'((k % 2 == 0) ? 1 : 3));

    // 4: serializer not ready holds off grants and the pointer
    apply_reset();
    req_en_i    = 4'b1111;
    req_valid_i = 4'b0001;
    run_until_grants(1, 20, "t4_first_grant");
    repeat (20) cycle();
    ser_ready_force = 1'b0;
    ser_ready_i     = 1'b0;
    req_valid_i     = 4'b0101;
    repeat (10) cycle();
    check("t4_no_grant", FROM'(grant_log.size()), FROM'(1));
    ser_ready_force = 1'b1;
    ser_ready_i     = !ser_busy_i;
    cycle();
    check("t4_grant_on_rise", FROM'(grant_log.size()), FROM'(2));
    check("t4_winner", FROM'(grant_log[grant_log.size()-1]), FROM'(2));
    repeat (20) cycle();

    // 5: watchdog on a stuck-busy serializer
    apply_reset();
    req_valid_i = '0;
    repeat (5) cycle();
    ser_stuck   = 1'b1;
    req_valid_i = 4'b0001;
    run_until_grants(1, 20, "t5_grant");
    repeat (WDOG + 4) cycle();
    check("t5_err_set", FROM'(err_o), FROM'(1));
    ser_stuck = 1'b0;
    s_cnt     = 0;
    req_valid_i[1] = 1'b1;
    run_until_grants(2, 30, "t5_regrant");
    repeat (10) cycle();
    check("t5_err_sticky", FROM'(err_o), FROM'(1));
    apply_reset();
    check("t5_err_cleared", FROM'(err_o), FROM'(0));

    // 6: reset in the middle of a stream
    req_valid_i = 4'b0010;
    run_until_grants(1, 20, "t6_grant");
    repeat (2) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("t6_words", FROM'(words_o), FROM'(0));
    check("t6_tag_valid", FROM'(tag_valid_o), FROM'(0));
    check("t6_tag", FROM'(tag_id_o), FROM'(0));
    grant_log.delete();
    req_valid_i = 4'b1111;
    run_until_grants(1, 30, "t6_after");
    check("t6_first_after_reset", FROM'(grant_log[0]), FROM'(0));
    repeat (40) cycle();

    // 7: randomized traffic, enables and readiness
    apply_reset();
    req_mode = 2;
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) req_en_i = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      ser_ready_force = ($urandom_range(0, 9) != 0);
      cycle();
    end
    check("t7_words_vs_grants", FROM'(words_o + 16'(m_load)), FROM'(grant_log.size()));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
